// File: rtl/dlsc_px_timing_out_pkg.sv
// dlsc_px_timing_out_pkg: shared state encodings and skip-zero next-state helper
package dlsc_px_timing_out_pkg;
  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_FP     = 2'd1;
  localparam logic [1:0] ST_SYNC   = 2'd2;
  localparam logic [1:0] ST_BP     = 2'd3;
  typedef enum logic {IDLE, RUN} run_t;
  // zero[s] marks a zero-length state; ACTIVE is never zero, so three hops always terminate
  function automatic logic [1:0] next_st(input logic [1:0] st, input logic [3:0] zero);
    logic [1:0] n;
    n = st + 2'd1;
    for (int i = 0; i < 3; i++) n = zero[n] ? n + 2'd1 : n;
    return n;
  endfunction
endpackage

// File: rtl/dlsc_px_timing_axis.sv
// dlsc_px_timing_axis: four-state ACTIVE/FP/SYNC/BP length counter with zero-length skipping
module dlsc_px_timing_axis
  import dlsc_px_timing_out_pkg::*;
#(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         step,
  input  logic [W-1:0] len_active,
  input  logic [W-1:0] len_fp,
  input  logic [W-1:0] len_sync,
  input  logic [W-1:0] len_bp,
  output logic [1:0]   st,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  logic [W-1:0] len;
  logic [3:0]   zero;
  logic [1:0]   nst;
  logic         last;
  always_comb begin
    len  = st == ST_ACTIVE ? len_active : st == ST_FP ? len_fp : st == ST_SYNC ? len_sync : len_bp;
    zero = {len_bp == '0, len_sync == '0, len_fp == '0, 1'b0};
    last = (len == '0) || (cnt == len - 1'b1);
    nst  = next_st(st, zero);
    wrap = step && last && nst == ST_ACTIVE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st  <= ST_ACTIVE;
      cnt <= '0;
    end else if (clr) begin
      st  <= ST_ACTIVE;
      cnt <= '0;
    end else if (step) begin
      st  <= last ? nst : st;
      cnt <= last ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/dlsc_px_timing_out.sv
// dlsc_px_timing_out: raster timing generator pulling pixels; DLSC_PX_TIMING_UNDERFLOW_COUNT_EN adds underflow_count
module dlsc_px_timing_out
  import dlsc_px_timing_out_pkg::*;
#(
  parameter int                XBITS      = 11,
  parameter int                YBITS      = 11,
  parameter int                PX_DATA    = 24,
  parameter logic              HSYNC_POL  = 1'b0,
  parameter logic              VSYNC_POL  = 1'b0,
  parameter logic [PX_DATA-1:0] BLANK_DATA = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [XBITS-1:0]   cfg_h_active,
  input  logic [XBITS-1:0]   cfg_h_fp,
  input  logic [XBITS-1:0]   cfg_h_sync,
  input  logic [XBITS-1:0]   cfg_h_bp,
  input  logic [YBITS-1:0]   cfg_v_active,
  input  logic [YBITS-1:0]   cfg_v_fp,
  input  logic [YBITS-1:0]   cfg_v_sync,
  input  logic [YBITS-1:0]   cfg_v_bp,
  output logic               px_ready,
  input  logic               px_valid,
  input  logic [PX_DATA-1:0] px_data,
  output logic               vid_hsync,
  output logic               vid_vsync,
  output logic               vid_de,
  output logic [PX_DATA-1:0] vid_data,
  output logic               running,
  output logic               frame_start,
  output logic               underflow
`ifdef DLSC_PX_TIMING_UNDERFLOW_COUNT_EN
  , output logic [15:0]      underflow_count
`endif
);
  run_t             state, nstate;
  logic [XBITS-1:0] h_act, h_fp, h_sync, h_bp, h_cnt;
  logic [YBITS-1:0] v_act, v_fp, v_sync, v_bp, v_cnt;
  logic [1:0]       h_st, v_st;
  logic             h_wrap, v_wrap, load, starve, fs_now;
  dlsc_px_timing_axis #(.W(XBITS)) u_h (
    .clk(clk), .rst(rst), .clr(state == IDLE), .step(state == RUN),
    .len_active(h_act), .len_fp(h_fp), .len_sync(h_sync), .len_bp(h_bp),
    .st(h_st), .cnt(h_cnt), .wrap(h_wrap)
  );
  dlsc_px_timing_axis #(.W(YBITS)) u_v (
    .clk(clk), .rst(rst), .clr(state == IDLE), .step(h_wrap),
    .len_active(v_act), .len_fp(v_fp), .len_sync(v_sync), .len_bp(v_bp),
    .st(v_st), .cnt(v_cnt), .wrap(v_wrap)
  );
  always_comb begin
    nstate   = state == IDLE ? (enable ? RUN : IDLE) : (v_wrap && !enable ? IDLE : RUN);
    load     = enable && (state == IDLE || v_wrap);
    running  = state == RUN;
    px_ready = running && h_st == ST_ACTIVE && v_st == ST_ACTIVE;
    starve   = px_ready && !px_valid;
    fs_now   = px_ready && h_cnt == '0 && v_cnt == '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nstate;
  // config is only sampled at frame boundaries so a frame never changes shape mid-way
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {h_act, h_fp, h_sync, h_bp} <= '0;
      {v_act, v_fp, v_sync, v_bp} <= '0;
    end else if (load) begin
      {h_act, h_fp, h_sync, h_bp} <= {cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp};
      {v_act, v_fp, v_sync, v_bp} <= {cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp};
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vid_hsync   <= ~HSYNC_POL;
      vid_vsync   <= ~VSYNC_POL;
      vid_de      <= 1'b0;
      vid_data    <= BLANK_DATA;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      vid_hsync   <= running && h_st == ST_SYNC ? HSYNC_POL : ~HSYNC_POL;
      vid_vsync   <= running && v_st == ST_SYNC ? VSYNC_POL : ~VSYNC_POL;
      vid_de      <= px_ready;
      vid_data    <= px_ready && px_valid ? px_data : BLANK_DATA;
      frame_start <= fs_now;
      underflow   <= starve;
    end
`ifdef DLSC_PX_TIMING_UNDERFLOW_COUNT_EN
  logic [15:0] uf_acc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      uf_acc          <= '0;
      underflow_count <= '0;
    end else if (fs_now) begin
      underflow_count <= uf_acc;
      uf_acc          <= {15'd0, starve};
    end else if (starve && uf_acc != '1) begin
      uf_acc <= uf_acc + 16'd1;
    end
`endif
endmodule

// File: tb/tb_dlsc_px_timing_out.sv
// tb_dlsc_px_timing_out: table-driven raster checks against a position-based reference model
module tb_dlsc_px_timing_out;
  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, starve, period, npx;
  } row_t;
  typedef struct packed {
    logic hs, vs, de, fs, uf;
    logic [23:0] data;
  } out_t;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, px_valid = 1'b0;
  logic [23:0] px_data = '0;
  logic [10:0] cfg_h_active = '0, cfg_h_fp = '0, cfg_h_sync = '0, cfg_h_bp = '0;
  logic [10:0] cfg_v_active = '0, cfg_v_fp = '0, cfg_v_sync = '0, cfg_v_bp = '0;
  logic px_ready, vid_hsync, vid_vsync, vid_de, running, frame_start, underflow;
  logic [23:0] vid_data;
`ifdef DLSC_PX_TIMING_UNDERFLOW_COUNT_EN
  logic [15:0] underflow_count;
`endif
  int checks = 0, errors = 0;
  row_t rows[5];
  out_t sb[$];
  bit mrun = 0;
  int pos = 0, fno = 0, mha = 1, mhf = 0, mhs = 0, mhb = 0, mva = 1, mvf = 0, mvs = 0, mvb = 0;
  int starve_left = 0, cyc_no = 0, last_fs = 0, de_cnt = 0, uf_tot = 0, uf_since = 0;
  int exp_period = 0, exp_px = 0;
  bit have_prev = 0;
  dlsc_px_timing_out dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
    .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
    .px_ready(px_ready), .px_valid(px_valid), .px_data(px_data),
    .vid_hsync(vid_hsync), .vid_vsync(vid_vsync), .vid_de(vid_de), .vid_data(vid_data),
    .running(running), .frame_start(frame_start), .underflow(underflow)
`ifdef DLSC_PX_TIMING_UNDERFLOW_COUNT_EN
    , .underflow_count(underflow_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", n, cyc_no, act, exp);
    end
  endtask
  task automatic set_cfg(input row_t r);
    {cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp} = {11'(r.ha), 11'(r.hf), 11'(r.hs), 11'(r.hb)};
    {cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp} = {11'(r.va), 11'(r.vf), 11'(r.vs), 11'(r.vb)};
  endtask
  task automatic latch_model();
    mha = int'(cfg_h_active); mhf = int'(cfg_h_fp); mhs = int'(cfg_h_sync); mhb = int'(cfg_h_bp);
    mva = int'(cfg_v_active); mvf = int'(cfg_v_fp); mvs = int'(cfg_v_sync); mvb = int'(cfg_v_bp);
  endtask
  task automatic check_reset_values(input string n);
    chk({n, "_out"}, {vid_hsync, vid_vsync, vid_de, frame_start, underflow, vid_data}, {5'b11000, 24'd0});
    chk({n, "_ctl"}, {running, px_ready}, 2'b00);
`ifdef DLSC_PX_TIMING_UNDERFLOW_COUNT_EN
    chk({n, "_ucount"}, underflow_count, 0);
`endif
  endtask
  // one clock: drive at negedge, predict, push; compare popped prediction at next negedge
  task automatic step(input bit en);
    int ha, va, ht, vt, x, l;
    bit de, vld;
    out_t e, a;
    ha = mha == 0 ? 1 : mha;
    va = mva == 0 ? 1 : mva;
    ht = ha + mhf + mhs + mhb;
    vt = va + mvf + mvs + mvb;
    x = pos % ht;
    l = pos / ht;
    de = mrun && x < ha && l < va;
    vld = 1'b1;
    if (de && fno == 1 && starve_left > 0) begin
      vld = 1'b0;
      starve_left--;
    end
    enable = en;
    px_valid = vld;
    px_data = 24'($urandom);
    #1;
    chk("ctl", {running, px_ready}, {mrun, de});
    e.hs = !(mrun && x >= ha + mhf && x < ha + mhf + mhs);
    e.vs = !(mrun && l >= va + mvf && l < va + mvf + mvs);
    e.de = de;
    e.fs = de && pos == 0;
    e.uf = de && !vld;
    e.data = de && vld ? px_data : 24'd0;
    sb.push_back(e);
    if (!mrun) begin
      if (en) begin
        mrun = 1; pos = 0; fno = 0;
        latch_model();
      end
    end else begin
      pos++;
      if (pos == ht * vt) begin
        if (en) begin
          pos = 0; fno++;
          latch_model();
        end else mrun = 0;
      end
    end
    @(negedge clk);
    cyc_no++;
    e = sb.pop_front();
    a = {vid_hsync, vid_vsync, vid_de, frame_start, underflow, vid_data};
    chk("vid", a, e);
    if (frame_start) begin
      if (have_prev) begin
        chk("period", cyc_no - last_fs, exp_period);
        chk("pixels", de_cnt, exp_px);
      end
`ifdef DLSC_PX_TIMING_UNDERFLOW_COUNT_EN
      chk("underflow_count", underflow_count, uf_since);
`endif
      uf_since = 0; de_cnt = 0; last_fs = cyc_no; have_prev = 1;
    end
    de_cnt += int'(vid_de);
    uf_tot += int'(underflow);
    uf_since += int'(e.uf);
  endtask
  task automatic drain();
    int n;
    for (n = 0; n < 2000 && mrun; n++) step(1'b0);
    chk("drain_timeout", mrun, 0);
    repeat (3) step(1'b0);
  endtask
  task automatic run_row(input int r);
    set_cfg(rows[r]);
    starve_left = rows[r].starve;
    exp_period = rows[r].period;
    exp_px = rows[r].npx;
    have_prev = 0;
    uf_tot = 0;
    for (int n = 0; n < 4000 && !(mrun && fno == 3); n++) step(1'b1);
    chk("frames_timeout", fno, 3);
    drain();
    chk("uf_total", uf_tot, rows[r].starve);
  endtask
  initial begin
    rows[0] = '{4, 1, 2, 1, 3, 1, 1, 1, 0, 48, 12};
    rows[1] = '{4, 0, 1, 0, 2, 0, 1, 0, 0, 15, 8};
    rows[2] = '{3, 0, 0, 0, 2, 0, 0, 0, 0, 6, 6};
    rows[3] = '{0, 1, 1, 1, 1, 1, 0, 1, 0, 12, 1};
    rows[4] = '{4, 1, 2, 1, 3, 1, 1, 1, 3, 48, 12};
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    for (int r = 0; r < 5; r++) run_row(r);
    // config change and enable drop mid-frame: current frame keeps old shape
    set_cfg(rows[0]);
    have_prev = 0;
    exp_period = 48;
    exp_px = 12;
    for (int n = 0; n < 500 && !(mrun && fno == 1 && pos == 20); n++) step(1'b1);
    cfg_h_active = 11'd6;
    drain();
    have_prev = 0;
    exp_period = 60;
    exp_px = 18;
    for (int n = 0; n < 500 && !(mrun && fno == 1 && pos == 1); n++) step(1'b1);
    chk("reenable_timeout", {mrun, 8'(fno), 8'(pos)}, {1'b1, 8'd1, 8'd1});
    drain();
    // async reset in the middle of an active line
    set_cfg(rows[0]);
    have_prev = 0;
    exp_period = 48;
    exp_px = 12;
    for (int n = 0; n < 500 && !(mrun && pos == 10); n++) step(1'b1);
    chk("pre_reset_de", vid_de, 1);
    #2 rst = 1'b1;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    check_reset_values("held_reset");
    rst = 1'b0;
    mrun = 0; pos = 0; fno = 0; sb.delete(); have_prev = 0; uf_since = 0;
    begin
      bit seen;
      seen = 0;
      for (int n = 0; n < 100 && !seen; n++) begin
        step(1'b1);
        if (vid_de) begin
          seen = 1;
          chk("restart_fs_first_de", frame_start, 1);
        end
      end
      chk("restart_de_seen", seen, 1);
    end
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
